// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with PC, retire counter and misalignment trap.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc_out,
    input  logic        instr_ready,
    input  logic [31:0] pc_next_in,
    input  logic        halt_in,
    output logic        misaligned_out,
    output logic [31:0] retired_count_out
);
    typedef enum logic [2:0] {ISSUE, WAIT, VALID, IDLE, ERROR} state_t;
    state_t state, state_nx;
    logic [31:0] pc, instr, instr_pc, retired_count;
    logic misaligned, retire, bad_target;
    always_comb begin
        retire = state == VALID && instr_ready;
        bad_target = pc_next_in[1:0] != 2'b00;
        state_nx = state;
        unique case (state)
            ISSUE:   state_nx = imem_req_ready ? WAIT : ISSUE;
            WAIT:    state_nx = imem_resp_valid ? VALID : WAIT;
            VALID:   state_nx = !instr_ready ? VALID : bad_target ? ERROR : halt_in ? IDLE : ISSUE;
            IDLE:    state_nx = halt_in ? IDLE : ISSUE;
            default: state_nx = ERROR;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ISSUE;
            pc <= RESET_PC;
            instr <= '0;
            instr_pc <= RESET_PC;
            misaligned <= 1'b0;
            retired_count <= '0;
        end else begin
            state <= state_nx;
            if (state == WAIT && imem_resp_valid) begin
                instr <= imem_resp_data;
                instr_pc <= pc;
            end
            if (retire) begin
                retired_count <= retired_count + 32'd1;
                if (bad_target) misaligned <= 1'b1;
                else pc <= pc_next_in;
            end
        end
    end
    assign imem_req_valid = state == ISSUE;
    assign imem_req_addr = pc;
    assign instr_valid = state == VALID;
    assign instr_out = instr;
    assign instr_pc_out = instr_pc;
    assign misaligned_out = misaligned;
    assign retired_count_out = retired_count;
endmodule
